// File: rtl/data_bus_controller_if.sv
// Core data-bus port plus memory-side request/ready handshake, bundled.
// slave : the bridge (consumes core requests, drives the memory side)
// master: the environment (core stage + memory target)
interface data_bus_controller_if;
  logic [31:0] bus_address;
  logic        bus_read_enable;
  logic        bus_write_enable;
  logic [3:0]  bus_byte_enable;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_stall;
  logic        bus_error;
  logic        mem_request;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [3:0]  mem_byte_enable;
  logic [31:0] mem_write_data;
  logic        mem_ready;
  logic [31:0] mem_read_data;

  modport slave (
    input  bus_address, bus_read_enable, bus_write_enable, bus_byte_enable,
           bus_write_data, mem_ready, mem_read_data,
    output bus_read_data, bus_stall, bus_error, mem_request, mem_write,
           mem_address, mem_byte_enable, mem_write_data
  );

  modport master (
    output bus_address, bus_read_enable, bus_write_enable, bus_byte_enable,
           bus_write_data, mem_ready, mem_read_data,
    input  bus_read_data, bus_stall, bus_error, mem_request, mem_write,
           mem_address, mem_byte_enable, mem_write_data
  );
endinterface

// File: rtl/data_bus_controller.sv
// Bridge from the core data-bus port to a variable-latency request/ready
// target. One access at a time: capture in IDLE, hold in REQUEST until the
// target acks (or the watchdog fires), present results in DONE.
module data_bus_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic                  clock,
  input logic                  reset,
  data_bus_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, DONE} state_t;

  localparam bit          TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 16'd0
                                                           : 16'(TIMEOUT_CYCLES - 1);

  state_t      state_q;
  logic [31:0] addr_q;
  logic        wr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic        req_q;
  logic        err_q;
  logic [15:0] cnt_q, cnt_d;
  logic        access_d;
  logic        tmo_d;

  // An enable with no lanes selected is not an access at all.
  assign access_d = (bus.bus_read_enable | bus.bus_write_enable) &&
                    (bus.bus_byte_enable != 4'b0000);

  // Watchdog count saturates so very long waits never alias back to zero.
  assign cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
  assign tmo_d = TMO_EN && (cnt_q == TMO_LAST);

  // Access FSM with all bus/mem outputs registered.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      req_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          err_q <= 1'b0;
          if (access_d) begin
            addr_q  <= {bus.bus_address[31:2], 2'b00};
            wr_q    <= bus.bus_write_enable;  // write wins when both are high
            be_q    <= bus.bus_byte_enable;
            wdata_q <= bus.bus_write_data;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            state_q <= REQUEST;
          end
        end
        REQUEST: begin
          cnt_q <= cnt_d;
          // Ready takes priority over a timeout landing on the same cycle.
          if (bus.mem_ready) begin
            if (!wr_q) rdata_q <= bus.mem_read_data;
            req_q   <= 1'b0;
            state_q <= DONE;
          end else if (tmo_d) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            req_q   <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          // Core advances at the end of this cycle; held enables are ignored.
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          req_q   <= 1'b0;
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Stall rises in the capture cycle itself so the core never slips past it.
  assign bus.bus_stall       = ((state_q == IDLE) && access_d) || (state_q == REQUEST);
  assign bus.bus_read_data   = rdata_q;
  assign bus.bus_error       = err_q;
  assign bus.mem_request     = req_q;
  assign bus.mem_write       = wr_q;
  assign bus.mem_address     = addr_q;
  assign bus.mem_byte_enable = be_q;
  assign bus.mem_write_data  = wdata_q;

endmodule

// File: tb/tb_data_bus_controller.sv
// Directed bench for data_bus_controller with TIMEOUT_CYCLES = 4.
module tb_data_bus_controller;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int   tests  = 0;
  int   failed = 0;

  data_bus_controller_if bif();

  data_bus_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bif)
  );

  always #5 clock = ~clock;

  // Stimulus driver: issues one access and acts as the memory target,
  // raising mem_ready on REQUEST cycle index 'delay' (-1: never).
  // Returns observations; callers compare them against hand-derived values.
  task automatic do_access(
    input  logic [31:0] addr, input logic rd, input logic wr,
    input  logic [3:0]  be,   input logic [31:0] wd,
    input  int          delay, input logic [31:0] rdat,
    output int          stall_n, output int req_n, output logic stable,
    output logic [31:0] a0, output logic w0, output logic [3:0] be0,
    output logic [31:0] wd0, output logic err_done,
    output logic [31:0] rd_done, output logic expired);
    logic seen;
    stall_n = 0; req_n = 0; stable = 1'b1; seen = 1'b0; expired = 1'b1;
    a0 = '0; w0 = 1'b0; be0 = '0; wd0 = '0; err_done = 1'b0; rd_done = '0;
    bif.bus_address = addr; bif.bus_read_enable = rd; bif.bus_write_enable = wr;
    bif.bus_byte_enable = be; bif.bus_write_data = wd;
    bif.mem_read_data = rdat; bif.mem_ready = 1'b0;
    #1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (bif.bus_stall) stall_n++;
      if (bif.mem_request) begin
        if (!seen) begin
          a0 = bif.mem_address; w0 = bif.mem_write;
          be0 = bif.mem_byte_enable; wd0 = bif.mem_write_data; seen = 1'b1;
        end else if (bif.mem_address !== a0 || bif.mem_write !== w0 ||
                     bif.mem_byte_enable !== be0 || bif.mem_write_data !== wd0) begin
          stable = 1'b0;
        end
        bif.mem_ready = (req_n == delay);
        req_n++;
      end else begin
        bif.mem_ready = 1'b0;
        if (seen) begin
          err_done = bif.bus_error; rd_done = bif.bus_read_data; expired = 1'b0;
          bif.bus_read_enable = 1'b0; bif.bus_write_enable = 1'b0;
          break;
        end
      end
      @(posedge clock); #1;
    end
    bif.mem_ready = 1'b0;
  endtask

  task automatic test_reset();
    bif.bus_address = '0; bif.bus_read_enable = 0; bif.bus_write_enable = 0;
    bif.bus_byte_enable = '0; bif.bus_write_data = '0;
    bif.mem_ready = 0; bif.mem_read_data = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    tests++; if ({bif.mem_request, bif.mem_write, bif.bus_error, bif.bus_stall} !== 4'b0) begin
      failed++; $display("FAIL reset_ctl got=%b want=0000",
        {bif.mem_request, bif.mem_write, bif.bus_error, bif.bus_stall}); end
    tests++; if ({bif.bus_read_data, bif.mem_address, bif.mem_write_data, bif.mem_byte_enable} !== '0) begin
      failed++; $display("FAIL reset_data rd=%h addr=%h wd=%h be=%b want all 0",
        bif.bus_read_data, bif.mem_address, bif.mem_write_data, bif.mem_byte_enable); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_zero_wait_read();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    do_access(32'h1000_0004, 1, 0, 4'b1111, 32'h0, 0, 32'hCAFE_BABE,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex) begin failed++; $display("FAIL zw_bound no DONE seen"); end
    tests++; if (a0 !== 32'h1000_0004) begin failed++; $display("FAIL zw_addr got=%h want=10000004", a0); end
    tests++; if (w0 !== 1'b0) begin failed++; $display("FAIL zw_write got=%b want=0", w0); end
    tests++; if (sn != 2) begin failed++; $display("FAIL zw_stall got=%0d want=2", sn); end
    tests++; if (rn != 1) begin failed++; $display("FAIL zw_req got=%0d want=1", rn); end
    tests++; if (rdd !== 32'hCAFE_BABE) begin failed++; $display("FAIL zw_rdata got=%h want=cafebabe", rdd); end
    @(posedge clock); #1;
    tests++; if ({bif.mem_request, bif.bus_error, bif.bus_stall} !== 3'b0) begin
      failed++; $display("FAIL zw_idle got=%b want=000", {bif.mem_request, bif.bus_error, bif.bus_stall}); end
  endtask

  task automatic test_byte_write();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    do_access(32'h0000_2003, 0, 1, 4'b1000, 32'hAB00_0000, 3, 32'hDEAD_0000,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex) begin failed++; $display("FAIL bw_bound no DONE seen"); end
    tests++; if (a0 !== 32'h0000_2000) begin failed++; $display("FAIL bw_addr got=%h want=00002000", a0); end
    tests++; if ({w0, be0} !== 5'b1_1000) begin failed++; $display("FAIL bw_wr_be got=%b want=11000", {w0, be0}); end
    tests++; if (wd0 !== 32'hAB00_0000) begin failed++; $display("FAIL bw_wdata got=%h want=ab000000", wd0); end
    tests++; if (!st) begin failed++; $display("FAIL bw_stable got=0 want=1"); end
    tests++; if (rn != 4) begin failed++; $display("FAIL bw_req got=%0d want=4", rn); end
    tests++; if (sn != 5) begin failed++; $display("FAIL bw_stall got=%0d want=5", sn); end
    tests++; if (rdd !== 32'hCAFE_BABE) begin failed++; $display("FAIL bw_rdata got=%h want=cafebabe", rdd); end
    tests++; if (er !== 1'b0) begin failed++; $display("FAIL bw_err got=%b want=0", er); end
    @(posedge clock); #1;
  endtask

  task automatic test_timeout();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    do_access(32'h0000_0100, 1, 0, 4'b0011, 32'h0, -1, 32'h7777_7777,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex) begin failed++; $display("FAIL to_bound no DONE seen"); end
    tests++; if (rn != 4) begin failed++; $display("FAIL to_req got=%0d want=4", rn); end
    tests++; if (er !== 1'b1) begin failed++; $display("FAIL to_err got=%b want=1", er); end
    tests++; if (rdd !== 32'h0) begin failed++; $display("FAIL to_rdata got=%h want=00000000", rdd); end
    @(posedge clock); #1;
    tests++; if ({bif.bus_error, bif.mem_request} !== 2'b00) begin
      failed++; $display("FAIL to_pulse got=%b want=00", {bif.bus_error, bif.mem_request}); end
  endtask

  task automatic test_ready_at_timeout();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    do_access(32'h0000_0200, 1, 0, 4'b1111, 32'h0, 3, 32'h1234_5678,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex || rn != 4) begin failed++; $display("FAIL rt_req got=%0d want=4", rn); end
    tests++; if (er !== 1'b0) begin failed++; $display("FAIL rt_err got=%b want=0", er); end
    tests++; if (rdd !== 32'h1234_5678) begin failed++; $display("FAIL rt_rdata got=%h want=12345678", rdd); end
    @(posedge clock); #1;
  endtask

  task automatic test_both_then_be0();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    int bad;
    do_access(32'h0000_0300, 1, 1, 4'b0001, 32'h0000_00EE, 0, 32'hFFFF_FFFF,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex || w0 !== 1'b1) begin failed++; $display("FAIL both_write got=%b want=1", w0); end
    tests++; if (rdd !== 32'h1234_5678) begin failed++; $display("FAIL both_rdata got=%h want=12345678", rdd); end
    @(posedge clock); #1;
    bif.bus_read_enable = 1; bif.bus_byte_enable = 4'b0000;
    bif.mem_ready = 1; bif.mem_read_data = 32'h5555_5555;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      #1;
      if (bif.bus_stall || bif.mem_request) bad++;
      @(posedge clock); #1;
    end
    tests++; if (bad != 0) begin failed++; $display("FAIL be0_noaccess got=%0d active cycles want=0", bad); end
    tests++; if (bif.bus_read_data !== 32'h1234_5678) begin
      failed++; $display("FAIL be0_rdata got=%h want=12345678", bif.bus_read_data); end
    bif.bus_read_enable = 0; bif.mem_ready = 0;
  endtask

  task automatic test_back_to_back();
    logic [5:0] reqv, stallv;
    bif.bus_address = 32'h0000_0400; bif.bus_read_enable = 1; bif.bus_write_enable = 0;
    bif.bus_byte_enable = 4'b1111; bif.mem_ready = 1; bif.mem_read_data = 32'h1111_1111;
    reqv = '0; stallv = '0;
    #1;
    for (int i = 0; i < 6; i++) begin
      reqv[i] = bif.mem_request; stallv[i] = bif.bus_stall;
      if (i == 5) begin bif.bus_read_enable = 0; bif.mem_ready = 0; end
      @(posedge clock); #1;
    end
    tests++; if (reqv !== 6'b010010) begin failed++; $display("FAIL b2b_req got=%b want=010010", reqv); end
    tests++; if (stallv !== 6'b011011) begin failed++; $display("FAIL b2b_stall got=%b want=011011", stallv); end
  endtask

  task automatic test_reset_mid_request();
    int sn, rn; logic st, w0, er, ex; logic [31:0] a0, wd0, rdd; logic [3:0] be0;
    bif.bus_address = 32'h0000_0500; bif.bus_read_enable = 0; bif.bus_write_enable = 1;
    bif.bus_byte_enable = 4'b1111; bif.bus_write_data = 32'h9999_9999; bif.mem_ready = 0;
    @(posedge clock); #1;   // IDLE -> REQUEST at this edge
    @(posedge clock); #1;   // now in 2nd REQUEST cycle
    tests++; if (bif.mem_request !== 1'b1) begin failed++; $display("FAIL rst_pre got=%b want=1", bif.mem_request); end
    reset = 1'b1;
    #1;
    tests++; if (bif.mem_request !== 1'b0) begin failed++; $display("FAIL rst_async got=%b want=0", bif.mem_request); end
    bif.bus_write_enable = 0;
    #1;
    tests++; if ({bif.bus_stall, bif.mem_write, bif.bus_error, bif.mem_address,
                  bif.mem_write_data, bif.mem_byte_enable, bif.bus_read_data} !== '0) begin
      failed++; $display("FAIL rst_vals stall=%b wr=%b err=%b addr=%h wd=%h be=%b rd=%h want all 0",
        bif.bus_stall, bif.mem_write, bif.bus_error, bif.mem_address,
        bif.mem_write_data, bif.mem_byte_enable, bif.bus_read_data); end
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    do_access(32'h0000_0044, 1, 0, 4'b1111, 32'h0, 1, 32'h55AA_55AA,
              sn, rn, st, a0, w0, be0, wd0, er, rdd, ex);
    tests++; if (ex || rn != 2 || sn != 3) begin
      failed++; $display("FAIL rst_fresh req=%0d stall=%0d want req=2 stall=3", rn, sn); end
    tests++; if (rdd !== 32'h55AA_55AA) begin failed++; $display("FAIL rst_fresh_rdata got=%h want=55aa55aa", rdd); end
    @(posedge clock); #1;
  endtask

  initial begin
    test_reset();
    test_zero_wait_read();
    test_byte_write();
    test_timeout();
    test_ready_at_timeout();
    test_both_then_be0();
    test_back_to_back();
    test_reset_mid_request();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
